// File: rtl/i_sram_like_responder_if.sv
// i_sram_like_responder_if: dual-issue instruction fetch sram-like bus
interface i_sram_like_responder_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok1;
  logic        inst_data_ok2;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;
  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok1, inst_data_ok2, inst_rdata1, inst_rdata2
  );
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok1, inst_data_ok2, inst_rdata1, inst_rdata2
  );
endinterface

// File: rtl/i_sram_like_responder.sv
// i_sram_like_responder: single-outstanding fetch responder returning one or two words from a sync RAM
module i_sram_like_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_hold,
  i_sram_like_responder_if.slave bus,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [2:0] {IDLE, WAIT, RD0, RD1, RD2, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] w0, w0_nx;
  logic pair, pair_nx, wr, wr_nx, ok1, ok2, accept, unused;
  logic [7:0] cnt;
  logic [31:0] rdata1, rdata2;
  assign accept = state == IDLE && bus.inst_req && !addr_hold;
  assign bus.inst_addr_ok = accept;
  assign bus.inst_data_ok1 = ok1;
  assign bus.inst_data_ok2 = ok2;
  assign bus.inst_rdata1 = rdata1;
  assign bus.inst_rdata2 = rdata2;
  assign unused = ^{bus.inst_size, bus.inst_wdata, bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0]};
  // Request fields as they will be after this edge, so outputs can be registered from next state
  assign w0_nx = accept ? bus.inst_addr[ADDR_W+1:2] : w0;
  assign pair_nx = accept ? !bus.inst_addr[2] && !bus.inst_wr : pair;
  assign wr_nx = accept ? bus.inst_wr : wr;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LATENCY > 0 ? WAIT : wr_nx ? RESP : RD0;
      WAIT:    if (cnt == 8'd1) state_nx = wr ? RESP : RD0;
      RD0:     state_nx = RD1;
      RD1:     state_nx = pair ? RD2 : RESP;
      RD2:     state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      w0       <= '0;
      pair     <= 1'b0;
      wr       <= 1'b0;
      cnt      <= '0;
      ok1      <= 1'b0;
      ok2      <= 1'b0;
      rdata1   <= '0;
      rdata2   <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nx;
      w0       <= w0_nx;
      pair     <= pair_nx;
      wr       <= wr_nx;
      cnt      <= accept ? 8'(LATENCY) : state == WAIT ? cnt - 8'd1 : cnt;
      ok1      <= state_nx == RESP;
      ok2      <= state_nx == RESP && pair_nx;
      mem_en   <= state_nx == RD0 || (state_nx == RD1 && pair_nx);
      mem_addr <= state_nx == RD0 ? w0_nx : state_nx == RD1 && pair_nx ? {w0_nx[ADDR_W-1:1], 1'b1} : mem_addr;
      if (state == RD1) rdata1 <= mem_rdata;
      if (state == RD2) rdata2 <= mem_rdata;
    end
endmodule

// File: tb/tb_i_sram_like_responder.sv
// tb_i_sram_like_responder: two responders (LATENCY 0 and 3) against a cycle-count reference model
module tb_i_sram_like_responder;
  localparam int AW = 12;
  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic        wr;
    int          hold;
    int          lat;
    logic        o2;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0, wr = '0, hold = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0] aok, ok1, ok2, men;
  logic [1:0][31:0] rd1, rd2;
  logic [1:0][AW-1:0] maddr;
  logic [31:0] ram [0:(1<<AW)-1];
  int checks = 0, errors = 0, ncyc = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [31:0] mrd;
    i_sram_like_responder_if bus();
    assign bus.inst_req = req[g];
    assign bus.inst_wr = wr[g];
    assign bus.inst_size = 2'd2;
    assign bus.inst_addr = addr[g];
    assign bus.inst_wdata = 32'hDEAD_BEEF;
    assign aok[g] = bus.inst_addr_ok;
    assign ok1[g] = bus.inst_data_ok1;
    assign ok2[g] = bus.inst_data_ok2;
    assign rd1[g] = bus.inst_rdata1;
    assign rd2[g] = bus.inst_rdata2;
    i_sram_like_responder #(.ADDR_W(AW), .LATENCY(g == 0 ? 0 : 3)) dut (
      .clk(clk), .rst(rst), .addr_hold(hold[g]), .bus(bus),
      .mem_en(men[g]), .mem_addr(maddr[g]), .mem_rdata(mrd)
    );
    always @(posedge clk) if (men[g]) mrd <= ram[maddr[g]];
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic int lat(input int i);
    return i == 0 ? 0 : 3;
  endfunction

  // Reference model: one outstanding request per responder, response cycle derived from acceptance cycle
  bit busy [2];
  bit mwr [2];
  bit mpair [2];
  int acc [2];
  int due [2];
  logic [AW-1:0] mw0 [2];
  logic [31:0] last1 [2];
  logic [31:0] last2 [2];
  logic em, rs;
  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        busy[i] = 1'b0;
        last1[i] = '0;
        last2[i] = '0;
        chk("rst_ok1", i, ok1[i], 0);
        chk("rst_ok2", i, ok2[i], 0);
        chk("rst_mem_en", i, men[i], 0);
        chk("rst_mem_addr", i, maddr[i], 0);
        chk("rst_rdata1", i, rd1[i], 0);
        chk("rst_rdata2", i, rd2[i], 0);
        chk("rst_addr_ok", i, aok[i], req[i] && !hold[i]);
      end else begin
        chk("addr_ok", i, aok[i], !busy[i] && req[i] && !hold[i]);
        em = busy[i] && !mwr[i] && (ncyc == acc[i] + 1 + lat(i) || (mpair[i] && ncyc == acc[i] + 2 + lat(i)));
        chk("mem_en", i, men[i], em);
        if (em) chk("mem_addr", i, maddr[i], ncyc == acc[i] + 1 + lat(i) ? mw0[i] : {mw0[i][AW-1:1], 1'b1});
        rs = busy[i] && ncyc == due[i];
        chk("data_ok1", i, ok1[i], rs);
        chk("data_ok2", i, ok2[i], rs && mpair[i]);
        if (rs) begin
          if (!mwr[i]) begin
            last1[i] = ram[mw0[i]];
            if (mpair[i]) last2[i] = ram[{mw0[i][AW-1:1], 1'b1}];
          end
          chk("rdata1", i, rd1[i], last1[i]);
          chk("rdata2", i, rd2[i], last2[i]);
          busy[i] = 1'b0;
        end else if (!busy[i] && req[i] && aok[i]) begin
          busy[i] = 1'b1;
          acc[i] = ncyc;
          mwr[i] = wr[i];
          mw0[i] = addr[i][AW+1:2];
          mpair[i] = !addr[i][2] && !wr[i];
          due[i] = ncyc + lat(i) + (wr[i] ? 1 : mpair[i] ? 4 : 3);
        end
      end
    end
  end

  task automatic do_req(input int i, input logic [31:0] a, input logic w, input int h, input int el,
                        input bit cd, input logic eo2, input logic [31:0] e1, input logic [31:0] e2);
    int n;
    @(posedge clk);
    #1;
    req[i] = 1'b1;
    addr[i] = a;
    wr[i] = w;
    hold[i] = h > 0;
    for (int k = 0; k < h; k++) begin
      @(negedge clk);
      chk("held_off", i, aok[i], 0);
    end
    if (h > 0) begin
      @(posedge clk);
      #1 hold[i] = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!aok[i] && n < 50);
    chk("accept_wait", i, n, 1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    hold[i] = 1'($urandom % 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!ok1[i] && n < 60);
    chk("latency", i, n, el);
    chk("resp_ok2", i, ok2[i], eo2);
    if (cd) begin
      chk("resp_rdata1", i, rd1[i], e1);
      chk("resp_rdata2", i, rd2[i], e2);
    end
    hold[i] = 1'b0;
  endtask

  task automatic b2b(input int i, input logic [31:0] a, input int eok, input int egap);
    int n, t;
    @(posedge clk);
    #1;
    req[i] = 1'b1;
    addr[i] = a;
    wr[i] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!aok[i] && n < 50);
    chk("b2b_accept", i, n, 1);
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      n++;
      if (ok1[i] && t == 0) t = n;
    end while (!aok[i] && n < 60);
    chk("b2b_ok_cycle", i, t, eok);
    chk("b2b_gap", i, n, egap);
    @(posedge clk);
    #1 req[i] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ok1[i] && n < 60);
    chk("b2b_second_ok", i, n, eok);
  endtask

  initial begin
    vec_t tbl [8];
    int n, ri, rh, rl;
    logic [31:0] ra;
    logic rw;
    for (int k = 0; k < (1 << AW); k++) ram[k] = $urandom;
    ram[12'h010] = 32'hAAAA_0001;
    ram[12'h011] = 32'hBBBB_0002;
    ram[12'h012] = 32'h1234_5678;
    ram[12'h013] = 32'hCAFE_F00D;
    ram[12'hFFE] = 32'h0FFE_0FFE;
    ram[12'hFFF] = 32'h0FFF_0FFF;
    tbl[0] = '{0, 32'h0000_0040, 1'b0, 0, 4, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002};
    tbl[1] = '{0, 32'h0000_0044, 1'b0, 0, 3, 1'b0, 32'hBBBB_0002, 32'hBBBB_0002};
    tbl[2] = '{0, 32'h0000_0040, 1'b1, 0, 1, 1'b0, 32'hBBBB_0002, 32'hBBBB_0002};
    tbl[3] = '{1, 32'h0000_0040, 1'b0, 0, 7, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002};
    tbl[4] = '{1, 32'h0000_0040, 1'b1, 0, 4, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002};
    tbl[5] = '{0, 32'h0000_0048, 1'b0, 5, 4, 1'b1, 32'h1234_5678, 32'hCAFE_F00D};
    tbl[6] = '{1, 32'h0000_004F, 1'b0, 0, 6, 1'b0, 32'hCAFE_F00D, 32'hBBBB_0002};
    tbl[7] = '{0, 32'hABCD_3FF8, 1'b0, 0, 4, 1'b1, 32'h0FFE_0FFE, 32'h0FFF_0FFF};
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int t = 0; t < 8; t++)
      do_req(tbl[t].inst, tbl[t].addr, tbl[t].wr, tbl[t].hold, tbl[t].lat, 1'b1, tbl[t].o2, tbl[t].d1, tbl[t].d2);
    b2b(0, 32'h40, 4, 5);
    b2b(1, 32'h40, 7, 8);
    // Reset dropped while the pair read sits in RD1
    @(posedge clk);
    #1;
    req[0] = 1'b1;
    addr[0] = 32'h40;
    wr[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!aok[0] && n < 50);
    chk("rst_seq_accept", 0, n, 1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ok1", 0, ok1[0], 0);
    chk("rst_mid_mem_en", 0, men[0], 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_resp_after_rst", 0, ok1[0], 0);
    end
    do_req(0, 32'h40, 1'b0, 0, 4, 1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002);
    for (int k = 0; k < 40; k++) begin
      ri = int'($urandom % 2);
      ra = $urandom;
      rw = ($urandom % 4) == 0;
      rh = int'($urandom % 3);
      rl = lat(ri) + (rw ? 1 : !ra[2] ? 4 : 3);
      do_req(ri, ra, rw, rh, rl, 1'b0, !ra[2] && !rw, 32'h0, 32'h0);
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i_sram_like_responder.md
# i_sram_like_responder

Instruction-side sram-like responder: the slave end of the dual-issue fetch interface driven by the core's instruction sram-to-sram-like converter. It accepts one fetch request at a time, reads one or two consecutive words from a single-port synchronous instruction RAM, and returns them on `inst_data_ok1`/`inst_data_ok2`. It has a configurable response delay and an address-stall input, so the same block serves as the fetch-side memory model for core-level simulation and as the on-chip boot/instruction ROM responder.

## Interface
- `ADDR_W`, default 12: word-index width of the backing RAM (capacity 2^ADDR_W words).
- `LATENCY`, default 0: extra idle cycles inserted between request acceptance and the first RAM read (0..255).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state.
- `addr_hold`  in  1  when 1, `inst_addr_ok` is forced to 0 (stall injection).
- `inst_req`  in  1  request valid.
- `inst_wr`  in  1  1 = write request (not supported; acknowledged and discarded).
- `inst_size`  in  2  ignored (fetches are always word).
- `inst_addr`  in  32  byte address; bits [1:0] ignored.
- `inst_wdata`  in  32  ignored.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok1`  out  1  first word valid (one-cycle pulse).
- `inst_data_ok2`  out  1  second word valid; only ever high together with `inst_data_ok1`.
- `inst_rdata1`  out  32  first word.
- `inst_rdata2`  out  32  second word.
- `mem_en`  out  1  RAM read enable.
- `mem_addr`  out  ADDR_W  RAM word index.
- `mem_rdata`  in  32  RAM read data, valid the cycle after `mem_en`.

## Operation
- States: IDLE, WAIT, RD0, RD1, RD2, RESP.
- `inst_addr_ok` = (state==IDLE) & `inst_req` & ~`addr_hold` (combinational). Only one request outstanding.
- On acceptance latch: word index w0 = `inst_addr[ADDR_W+1:2]`, pair = ~`inst_addr[2]` & ~`inst_wr`, wr = `inst_wr`; load delay counter with LATENCY.
- IDLE -> WAIT if LATENCY>0, else -> RD0 (read) or RESP (write).
- WAIT: decrement counter each cycle; at count 1 -> RD0 (read) or RESP (write).
- RD0: `mem_en`=1, `mem_addr`=w0 -> RD1.
- RD1: capture `mem_rdata` into rdata1 reg. If pair: `mem_en`=1, `mem_addr`={w0[ADDR_W-1:1],1'b1} -> RD2; else -> RESP. Pair word never crosses an 8-byte boundary, so no index wrap occurs.
- RD2: capture `mem_rdata` into rdata2 reg -> RESP.
- RESP: `inst_data_ok1`=1, `inst_data_ok2`=pair -> IDLE.
- Write request: no `mem_en`, rdata regs unchanged, responds with `inst_data_ok1`=1, `inst_data_ok2`=0.
- `inst_rdata1/2` are registers; they hold their last value outside RESP and are meaningful only with their data_ok.
- `mem_en`=0 and `mem_addr` holds last value in all states other than RD0/RD1 (pair).

## Timing
- Reset: state IDLE; `inst_addr_ok` follows the IDLE equation (0 while `inst_req`=0); `inst_data_ok1/2`=0, `inst_rdata1/2`=0, `mem_en`=0, `mem_addr`=0, counter 0. Reset asserted mid-transaction drops it: no data_ok is ever produced for it.
- Acceptance cycle = A (`inst_req` & `inst_addr_ok` high at edge A).
- Single-word read: data_ok in cycle A+3+LATENCY.
- Pair read: data_ok1 and data_ok2 together in cycle A+4+LATENCY.
- Write: data_ok1 in cycle A+1+LATENCY.
- data_ok pulses are exactly one cycle. Earliest next acceptance is the cycle after RESP, so back-to-back pair reads with LATENCY=0 complete one every 5 cycles.
- `addr_hold` affects acceptance only; raising it after acceptance does not delay the response.
- `inst_req` dropping in a non-IDLE state has no effect; the master must hold `inst_req` until `inst_addr_ok`.

## Test plan
- RAM[0x10]=0xAAAA0001, RAM[0x11]=0xBBBB0002, LATENCY=0; read 0x40 at A -> cycle A+4: ok1=ok2=1, rdata1=0xAAAA0001, rdata2=0xBBBB0002; `mem_en` high only in A+1, A+2.
- Read 0x44 -> cycle A+3: ok1=1, ok2=0, rdata1=0xBBBB0002; exactly one `mem_en` pulse (addr 0x11).
- LATENCY=3, read 0x40 -> data_ok at A+7; `inst_addr_ok`=0 from A+1 through A+7 even with `inst_req` held high; accepted again in A+8.
- `inst_wr`=1, addr 0x40 -> ok1=1, ok2=0 at A+1; no `mem_en`; rdata1 keeps its previous value.
- `addr_hold`=1 for 5 cycles with `inst_req`=1 -> no acceptance; release -> accept the same cycle; normal latency.
- Assert `rst`=0 in RD1 of a pair read, release -> no data_ok, outputs 0, a new request is accepted immediately and returns correct data.
